maquina_estados_mascota: RTL

// - Pet-behaviour FSM directly downstream of the need-level modes stage: consumes the four 2-bit need levels
//   (animo, energia, descanso, medicina) plus test-button signals, decides the pet's displayed state.
// - Feeds back Activo_Comida / Activo_Medicina to gate the food/medicine level-raise paths.
// - Drives state code + change pulse to the display/animation stage.

---
 rtl/maquina_estados_mascota_pkg.sv | 56 +++++
 rtl/maquina_estados_mascota_divisor_tick.sv | 30 +++
 rtl/maquina_estados_mascota.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/maquina_estados_mascota_pkg.sv
// rtl/maquina_estados_mascota_pkg.sv - pet state codes, level thresholds and candidate-state helpers
package maquina_estados_mascota_pkg;

   localparam logic [2:0] COD_NEUTRAL    = 3'd0;
   localparam logic [2:0] COD_FELIZ      = 3'd1;
   localparam logic [2:0] COD_HAMBRIENTO = 3'd2;
   localparam logic [2:0] COD_CANSADO    = 3'd3;
   localparam logic [2:0] COD_TRISTE     = 3'd4;
   localparam logic [2:0] COD_ENFERMO    = 3'd5;
   localparam logic [2:0] COD_MUERTO     = 3'd6;

   localparam logic [1:0] NIVEL_CRITICO  = 2'd0;
   localparam logic [1:0] NIVEL_ALTO     = 2'd2;

   typedef enum logic [2:0] {
      NEUTRAL    = COD_NEUTRAL,
      FELIZ      = COD_FELIZ,
      HAMBRIENTO = COD_HAMBRIENTO,
      CANSADO    = COD_CANSADO,
      TRISTE     = COD_TRISTE,
      ENFERMO    = COD_ENFERMO,
      MUERTO     = COD_MUERTO
   } estado_t;

   // Earlier tests win: sickness masks hunger, hunger masks tiredness, and so on.
   function automatic estado_t candidato(input logic [1:0] animo,
                                         input logic [1:0] energia,
                                         input logic [1:0] descanso,
                                         input logic [1:0] medicina);
      estado_t res;
      if (medicina == NIVEL_CRITICO)
         res = ENFERMO;
      else if (energia == NIVEL_CRITICO)
         res = HAMBRIENTO;
      else if (descanso == NIVEL_CRITICO)
         res = CANSADO;
      else if (animo == NIVEL_CRITICO)
         res = TRISTE;
      else if (animo >= NIVEL_ALTO && energia >= NIVEL_ALTO &&
               descanso >= NIVEL_ALTO && medicina >= NIVEL_ALTO)
         res = FELIZ;
      else
         res = NEUTRAL;
      return res;
   endfunction

   function automatic estado_t siguiente_prueba(input estado_t e);
      estado_t res;
      if (e == MUERTO)
         res = NEUTRAL;
      else
         res = estado_t'(e + 3'd1);
      return res;
   endfunction

endpackage

// File: rtl/maquina_estados_mascota_divisor_tick.sv
// rtl/maquina_estados_mascota_divisor_tick.sv - free-running divider, one-clk tick every TICK_DIV clks
module divisor_tick #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (tick)
         cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/maquina_estados_mascota.sv
// rtl/maquina_estados_mascota.sv - pet behaviour FSM with hold filter and test mode
// Optional MUERTE_EN: ENFERMO for DEATH_TICKS ticks leads to a sticky MUERTO.
module maquina_estados_mascota
   import maquina_estados_mascota_pkg::*;
#(
   parameter int TICK_DIV    = 50_000_000,
   parameter int HOLD_TICKS  = 3,
   parameter int DEATH_TICKS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Nivel_Animo,
   input  logic [1:0] Nivel_Energia,
   input  logic [1:0] Nivel_Descanso,
   input  logic [1:0] Nivel_Medicina,
   input  logic       Senal_MTest,
   input  logic       Senal_Test,
   output logic [2:0] Estado,
   output logic       Cambio_Estado,
   output logic       Activo_Comida,
   output logic       Activo_Medicina,
   output logic [7:0] Tiempo_Vida
);

   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   if (HOLD_TICKS < 1 || DEATH_TICKS < 1 || TICK_DIV < 2) begin : g_param_invalido
      $error("maquina_estados_mascota: parameter out of range");
   end

   logic tick;

   divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor_tick (
      .clk  (clk),
      .rst_n(reset),
      .tick (tick)
   );

   estado_t             estado_q, estado_d;
   estado_t             pend_q, pend_d;
   estado_t             cand;
   logic [HOLD_W-1:0]   hold_q, hold_d, hold_sig;
   logic [7:0]          vida_q, vida_d;
   logic                mtest_q, mtest_d;
   logic                cambio_q, cambio_d;
   logic                comida_q, comida_d;
   logic                medic_q, medic_d;
   logic                salida_test;
   logic                evaluar;

`ifdef MUERTE_EN
   localparam int SICK_W = $clog2(DEATH_TICKS + 1);
   logic [SICK_W-1:0]   sick_q, sick_d, sick_inc;
`endif

   assign cand        = candidato(Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina);
   assign salida_test = mtest_q && !Senal_MTest;

   always_comb begin
      estado_d = estado_q;
      pend_d   = pend_q;
      hold_d   = hold_q;
      hold_sig = '0;
      vida_d   = vida_q;
      mtest_d  = Senal_MTest;
      evaluar  = 1'b0;
`ifdef MUERTE_EN
      sick_d   = sick_q;
      sick_inc = sick_q + 1'b1;
`endif

      if (salida_test) begin
         estado_d = NEUTRAL;
         pend_d   = NEUTRAL;
         hold_d   = '0;
      end else if (Senal_MTest) begin
         hold_d = '0;
         if (Senal_Test)
            estado_d = siguiente_prueba(estado_q);
      end else if (tick) begin
         if (estado_q != MUERTO && vida_q != 8'hFF)
            vida_d = vida_q + 8'd1;
         evaluar = 1'b1;
`ifdef MUERTE_EN
         if (estado_q == MUERTO) begin
            evaluar = 1'b0;
            hold_d  = '0;
         end else if (estado_q == ENFERMO) begin
            if (sick_inc >= SICK_W'(DEATH_TICKS)) begin
               estado_d = MUERTO;
               hold_d   = '0;
               evaluar  = 1'b0;
            end else begin
               sick_d = sick_inc;
            end
         end
`endif
      end

      // A candidate must be seen HOLD_TICKS consecutive ticks before it is adopted.
      if (evaluar) begin
         if (cand == estado_q) begin
            hold_d = '0;
         end else begin
            hold_sig = (cand == pend_q) ? hold_q + 1'b1 : HOLD_W'(1);
            pend_d   = cand;
            if (hold_sig >= HOLD_W'(HOLD_TICKS)) begin
               estado_d = cand;
               hold_d   = '0;
            end else begin
               hold_d = hold_sig;
            end
         end
      end

      if (estado_q == estado_t'(3'd7))
         estado_d = NEUTRAL;

`ifdef MUERTE_EN
      if (estado_d != ENFERMO || Senal_MTest || salida_test)
         sick_d = '0;
`endif

      cambio_d = (estado_d != estado_q);
      comida_d = !(estado_d == MUERTO || Senal_MTest);
      medic_d  = (estado_d == ENFERMO);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q <= NEUTRAL;
         pend_q   <= NEUTRAL;
         hold_q   <= '0;
         vida_q   <= '0;
         mtest_q  <= 1'b0;
         cambio_q <= 1'b0;
         comida_q <= 1'b1;
         medic_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         pend_q   <= pend_d;
         hold_q   <= hold_d;
         vida_q   <= vida_d;
         mtest_q  <= mtest_d;
         cambio_q <= cambio_d;
         comida_q <= comida_d;
         medic_q  <= medic_d;
      end
   end

`ifdef MUERTE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sick_q <= '0;
      else
         sick_q <= sick_d;
   end
`endif

   assign Estado          = estado_q;
   assign Cambio_Estado   = cambio_q;
   assign Activo_Comida   = comida_q;
   assign Activo_Medicina = medic_q;
   assign Tiempo_Vida     = vida_q;

endmodule
